// File: rtl/kernel_pr_start_sched_pkg.sv
// Shared types and constants for the start-token scheduler.
// The optional watchdog is enabled with KERNEL_PR_START_SCHED_TIMEOUT_EN.
package kernel_pr_start_sched_pkg;

  localparam int STATE_W = 2;
  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/kernel_pr_start_sched_rr_arb.sv
// Combinational round-robin picker: first set request bit strictly after rr_ptr,
// wrapping modulo NUM_REQ.
module kernel_pr_start_sched_rr_arb #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               grant_valid,
  output logic [IDX_W-1:0]   grant_idx,
  output logic [NUM_REQ-1:0] grant
);

  // Scan farthest candidate first so the nearest one after rr_ptr wins.
  always_comb begin
    logic [IDX_W-1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    cand        = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/kernel_pr_start_sched.sv
// Start-token scheduler for one shared dataflow process: pops one start token per run,
// round-robin, and sequences ap_start/ap_ready/ap_done. Watchdog: KERNEL_PR_START_SCHED_TIMEOUT_EN.
module kernel_pr_start_sched
  import kernel_pr_start_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int IDX_W          = 2,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [NUM_REQ-1:0] req_empty_n,
  output logic [NUM_REQ-1:0] req_read,
  output logic               proc_ap_start,
  input  logic               proc_ap_ready,
  input  logic               proc_ap_done,
  output logic [IDX_W-1:0]   sel_idx,
  output logic               busy,
  output logic               done_pulse,
  output logic [IDX_W-1:0]   done_idx,
  output logic [CNT_W-1:0]   run_cnt,
  output logic               err_timeout
);

  if (IDX_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("kernel_pr_start_sched: IDX_W must equal clog2(NUM_REQ) and TIMEOUT_CYCLES must be positive");
  end

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               grant_valid;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               wd_expired;

  kernel_pr_start_sched_rr_arb #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_rr_arb (
    .req        (req_empty_n),
    .rr_ptr     (rr_ptr),
    .grant_valid(grant_valid),
    .grant_idx  (grant_idx),
    .grant      (grant)
  );

  // Pop happens in the grant cycle itself, so tokens are only sampled while idle.
  assign req_read = (state == IDLE && enable) ? grant : '0;

`ifdef KERNEL_PR_START_SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  logic [WD_W-1:0] wd_cnt;
  assign wd_expired = (state != IDLE) && (wd_cnt == WD_LIMIT);
`else
  assign wd_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      rr_ptr        <= IDX_W'(NUM_REQ - 1);
      sel_idx       <= '0;
      proc_ap_start <= 1'b0;
      busy          <= 1'b0;
      done_pulse    <= 1'b0;
      done_idx      <= '0;
      run_cnt       <= '0;
      err_timeout   <= 1'b0;
`ifdef KERNEL_PR_START_SCHED_TIMEOUT_EN
      wd_cnt        <= '0;
`endif
    end else begin
      done_pulse <= 1'b0;
      if (wd_expired) begin
        // Abandon the run without crediting it; the error stays until reset.
        state         <= IDLE;
        proc_ap_start <= 1'b0;
        busy          <= 1'b0;
        err_timeout   <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (enable && grant_valid) begin
              sel_idx       <= grant_idx;
              rr_ptr        <= grant_idx;
              proc_ap_start <= 1'b1;
              busy          <= 1'b1;
              state         <= START;
            end
          end
          START: begin
            if (proc_ap_ready) begin
              proc_ap_start <= 1'b0;
              if (proc_ap_done) begin
                done_pulse <= 1'b1;
                done_idx   <= sel_idx;
                run_cnt    <= run_cnt + CNT_W'(1);
                busy       <= 1'b0;
                state      <= IDLE;
              end else begin
                state <= WAIT_DONE;
              end
            end
          end
          WAIT_DONE: begin
            if (proc_ap_done) begin
              done_pulse <= 1'b1;
              done_idx   <= sel_idx;
              run_cnt    <= run_cnt + CNT_W'(1);
              busy       <= 1'b0;
              state      <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
`ifdef KERNEL_PR_START_SCHED_TIMEOUT_EN
      if (state == IDLE) wd_cnt <= '0;
      else               wd_cnt <= wd_cnt + WD_W'(1);
`endif
    end
  end

endmodule

// File: tb/tb_kernel_pr_start_sched.sv
// Directed self-checking bench for kernel_pr_start_sched (NUM_REQ=4, TIMEOUT_CYCLES=16).
// Inputs change on the falling edge; outputs are checked 1 time unit later.
module tb_kernel_pr_start_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  req_empty_n;
  logic [3:0]  req_read;
  logic        proc_ap_start;
  logic        proc_ap_ready;
  logic        proc_ap_done;
  logic [1:0]  sel_idx;
  logic        busy;
  logic        done_pulse;
  logic [1:0]  done_idx;
  logic [31:0] run_cnt;
  logic        err_timeout;

  int n_assert = 0;
  int n_fail   = 0;

  kernel_pr_start_sched #(
    .NUM_REQ(4), .IDX_W(2), .CNT_W(32), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .req_empty_n(req_empty_n),
    .req_read(req_read), .proc_ap_start(proc_ap_start), .proc_ap_ready(proc_ap_ready),
    .proc_ap_done(proc_ap_done), .sel_idx(sel_idx), .busy(busy), .done_pulse(done_pulse),
    .done_idx(done_idx), .run_cnt(run_cnt), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] req, input logic rdy, input logic dn);
    enable        = en;
    req_empty_n   = req;
    proc_ap_ready = rdy;
    proc_ap_done  = dn;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int g;
    reset = 1'b1;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    tick;
    tick;
    reset = 1'b0;
    applyStimulus(1'b0, 4'b0000, 1'b0, 1'b0);
    checkOutput("rst_start", 32'(proc_ap_start), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done_pulse", 32'(done_pulse), 32'd0);
    checkOutput("rst_sel_idx", 32'(sel_idx), 32'd0);
    checkOutput("rst_run_cnt", run_cnt, 32'd0);
    checkOutput("rst_err", 32'(err_timeout), 32'd0);
    checkOutput("rst_req_read", 32'(req_read), 32'd0);

    $display("[TB] single requester");
    applyStimulus(1'b1, 4'b0001, 1'b0, 1'b0);
    checkOutput("t1_pop", 32'(req_read), 32'h1);
    tick;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("t1_pop_once", 32'(req_read), 32'h0);
    checkOutput("t1_start_c1", 32'(proc_ap_start), 32'd1);
    checkOutput("t1_busy", 32'(busy), 32'd1);
    checkOutput("t1_sel", 32'(sel_idx), 32'd0);
    tick;
    checkOutput("t1_start_c2", 32'(proc_ap_start), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b0);
    tick;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("t1_start_drop", 32'(proc_ap_start), 32'd0);
    checkOutput("t1_busy_wait", 32'(busy), 32'd1);
    repeat (4) tick;
    checkOutput("t1_no_early_done", 32'(done_pulse), 32'd0);
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("t1_done_pulse", 32'(done_pulse), 32'd1);
    checkOutput("t1_done_idx", 32'(done_idx), 32'd0);
    checkOutput("t1_run_cnt", run_cnt, 32'd1);
    checkOutput("t1_busy_clr", 32'(busy), 32'd0);
    tick;
    checkOutput("t1_pulse_one_cycle", 32'(done_pulse), 32'd0);

    $display("[TB] all requesters pending, round robin");
    for (int k = 0; k < 4; k++) begin
      g = (k + 1) % 4;
      applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
      checkOutput("t2_pop", 32'(req_read), 32'(1 << g));
      tick;
      checkOutput("t2_sel", 32'(sel_idx), 32'(g));
      checkOutput("t2_start", 32'(proc_ap_start), 32'd1);
      checkOutput("t2_no_pop_in_start", 32'(req_read), 32'd0);
      applyStimulus(1'b1, 4'b1111, 1'b1, 1'b1);
      tick;
      checkOutput("t2_done_pulse", 32'(done_pulse), 32'd1);
      checkOutput("t2_done_idx", 32'(done_idx), 32'(g));
      checkOutput("t2_run_cnt", run_cnt, 32'(2 + k));
    end

    $display("[TB] ready and done together, requester 2");
    applyStimulus(1'b1, 4'b0100, 1'b0, 1'b0);
    checkOutput("t3_pop", 32'(req_read), 32'h4);
    tick;
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    checkOutput("t3_sel", 32'(sel_idx), 32'd2);
    checkOutput("t3_start", 32'(proc_ap_start), 32'd1);
    tick;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b1);
    checkOutput("t3_done_pulse", 32'(done_pulse), 32'd1);
    checkOutput("t3_done_idx", 32'(done_idx), 32'd2);
    checkOutput("t3_start_low", 32'(proc_ap_start), 32'd0);
    checkOutput("t3_idle", 32'(busy), 32'd0);
    checkOutput("t3_run_cnt", run_cnt, 32'd6);
    tick;
    checkOutput("t3_idle_done_ignored", 32'(done_pulse), 32'd0);
    checkOutput("t3_idle_cnt_hold", run_cnt, 32'd6);

    $display("[TB] enable dropped mid-run");
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    checkOutput("t4_pop", 32'(req_read), 32'h8);
    tick;
    checkOutput("t4_sel", 32'(sel_idx), 32'd3);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    tick;
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    checkOutput("t4_wait_busy", 32'(busy), 32'd1);
    tick;
    checkOutput("t4_wait_no_pop", 32'(req_read), 32'd0);
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b1);
    tick;
    applyStimulus(1'b0, 4'b1111, 1'b0, 1'b0);
    checkOutput("t4_done_pulse", 32'(done_pulse), 32'd1);
    checkOutput("t4_done_idx", 32'(done_idx), 32'd3);
    checkOutput("t4_run_cnt", run_cnt, 32'd7);
    checkOutput("t4_disabled_no_pop", 32'(req_read), 32'd0);
    tick;
    checkOutput("t4_disabled_idle", 32'(busy), 32'd0);
    checkOutput("t4_disabled_no_pop2", 32'(req_read), 32'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    checkOutput("t4_reenable_pop", 32'(req_read), 32'h1);
    tick;
    checkOutput("t4_reenable_sel", 32'(sel_idx), 32'd0);
    checkOutput("t4_reenable_start", 32'(proc_ap_start), 32'd1);
    applyStimulus(1'b1, 4'b1111, 1'b1, 1'b0);
    tick;
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    checkOutput("t4_in_wait", 32'(busy), 32'd1);

    $display("[TB] reset during WAIT_DONE");
    reset = 1'b1;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    tick;
    reset = 1'b0;
    applyStimulus(1'b1, 4'b0000, 1'b0, 1'b0);
    checkOutput("t5_start", 32'(proc_ap_start), 32'd0);
    checkOutput("t5_busy", 32'(busy), 32'd0);
    checkOutput("t5_done_idx", 32'(done_idx), 32'd0);
    checkOutput("t5_run_cnt", run_cnt, 32'd0);
    checkOutput("t5_err", 32'(err_timeout), 32'd0);
    applyStimulus(1'b1, 4'b1111, 1'b0, 1'b0);
    checkOutput("t5_first_pop", 32'(req_read), 32'h1);
    tick;
    checkOutput("t5_sel", 32'(sel_idx), 32'd0);
    checkOutput("t5_start_high", 32'(proc_ap_start), 32'd1);

`ifdef KERNEL_PR_START_SCHED_TIMEOUT_EN
    $display("[TB] watchdog timeout");
    repeat (16) tick;
    checkOutput("t6_err_not_yet", 32'(err_timeout), 32'd0);
    checkOutput("t6_still_busy", 32'(busy), 32'd1);
    tick;
    checkOutput("t6_err", 32'(err_timeout), 32'd1);
    checkOutput("t6_idle", 32'(busy), 32'd0);
    checkOutput("t6_start_low", 32'(proc_ap_start), 32'd0);
    checkOutput("t6_no_done", 32'(done_pulse), 32'd0);
    checkOutput("t6_run_cnt", run_cnt, 32'd0);
    checkOutput("t6_new_pop", 32'(req_read), 32'h2);
    tick;
    checkOutput("t6_new_sel", 32'(sel_idx), 32'd1);
    checkOutput("t6_err_sticky", 32'(err_timeout), 32'd1);
`else
    $display("[TB] watchdog absent, finish run normally");
    repeat (20) tick;
    checkOutput("t6_err_tied", 32'(err_timeout), 32'd0);
    checkOutput("t6_still_busy", 32'(busy), 32'd1);
    applyStimulus(1'b1, 4'b0000, 1'b1, 1'b1);
    tick;
    checkOutput("t6_done_pulse", 32'(done_pulse), 32'd1);
    checkOutput("t6_run_cnt", run_cnt, 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
